interrupt_sequencer: RTL and testbench

- Sits directly downstream of the processor status register. Consumes its RCL-facing copy of P and feeds back the break flag and I-flag set controls.
- Synchronises the external NMI and IRQ pins, detects the NMI edge, and gates IRQ with the I flag.
- At each instruction boundary, arbitrates between RESET, NMI, IRQ and BRK.
- Runs the 7-cycle interrupt micro-sequence: 2 dummy cycles, 3 stack pushes, 2 vector fetches.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/interrupt_sequencer_if.sv | 51 +++++
 rtl/pin_sync.sv | 38 +++
 rtl/interrupt_sequencer.sv | 171 +++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the interrupt sequencer slice: interrupt kinds,
//   vector base addresses, sequence length and the sequencer FSM states.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Number of cycles in every BRK/IRQ/NMI/RESET micro-sequence.
  localparam int SEQ_LEN = 7;

  // Low byte addresses of the vector pairs; the high byte is fetched at +1.
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;

  // Encoding is visible on the int_kind output.
  typedef enum logic [1:0] {
    BRK   = 2'b00,
    IRQ   = 2'b01,
    NMI   = 2'b10,
    RESET = 2'b11
  } int_kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } seq_state_t;

  // BRK shares the IRQ vector.
  function automatic logic [15:0] vector_base(input int_kind_t kind);
    case (kind)
      NMI:     return VEC_NMI;
      RESET:   return VEC_RST;
      default: return VEC_IRQ;
    endcase
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_if
//   Bundles the sequencer's pins and control-side signals.
//   master: the surrounding CPU/control (drives pins, status, boundary, rdy)
//   slave : the interrupt sequencer (drives busy, cycle, kind, bus controls)
//
//   nmi_n, irq_n     async active-low interrupt pins
//   psr_in[7:0]      processor status; bit 2 is the I flag
//   instr_boundary   last cycle of the current instruction
//   brk_decoded      opcode being started is BRK (valid with instr_boundary)
//   rdy              bus ready; sequence holds while low
//   busy             sequence in progress
//   seq_cycle[2:0]   current sequence cycle 0..6
//   int_kind[1:0]    00 BRK, 01 IRQ, 10 NMI, 11 RESET
//   stack_wr         stack push in cycles 2..4 (not for RESET)
//   vector_addr      vector fetch address in cycles 5/6, else 0
//   break_set        set B flag (cycle 4 of BRK)
//   manual_I         write I flag (cycle 5)
//   manual_set       value written with manual_I
// -----------------------------------------------------------------------------
interface interrupt_sequencer_if;

  logic        nmi_n;
  logic        irq_n;
  logic [7:0]  psr_in;
  logic        instr_boundary;
  logic        brk_decoded;
  logic        rdy;

  logic        busy;
  logic [2:0]  seq_cycle;
  logic [1:0]  int_kind;
  logic        stack_wr;
  logic [15:0] vector_addr;
  logic        break_set;
  logic        manual_I;
  logic        manual_set;

  modport master (
    output nmi_n, irq_n, psr_in, instr_boundary, brk_decoded, rdy,
    input  busy, seq_cycle, int_kind, stack_wr, vector_addr,
           break_set, manual_I, manual_set
  );

  modport slave (
    input  nmi_n, irq_n, psr_in, instr_boundary, brk_decoded, rdy,
    output busy, seq_cycle, int_kind, stack_wr, vector_addr,
           break_set, manual_I, manual_set
  );

endinterface

// File: rtl/pin_sync.sv
// -----------------------------------------------------------------------------
// pin_sync
//   STAGES-deep flop chain bringing an asynchronous pin into the clk domain.
//   Resets to 1 so an idle (high) active-low pin produces no spurious edge.
//
//   clk      system clock
//   rst      synchronous active-high reset
//   async_i  asynchronous pin
//   sync_o   synchronised pin (STAGES edges of latency)
// -----------------------------------------------------------------------------
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift toward the MSB; the MSB is the synchronised output.
  assign chain_d = (chain_q << 1) | STAGES'(async_i);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//   Synchronises NMI/IRQ pins, latches the NMI falling edge, arbitrates
//   RESET/NMI/IRQ/BRK at instruction boundaries and runs the 7-cycle
//   interrupt micro-sequence (2 dummy cycles, 3 pushes, 2 vector fetches).
//
//   clk   system clock
//   rst   synchronous active-high reset; (re)starts a RESET sequence
//   bus   interrupt_sequencer_if.slave (pins, status, control outputs)
//
//   All outputs decode registered state only; nothing from the pins reaches
//   an output combinationally.
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter int SEQ_LEN     = cpu_pkg::SEQ_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  interrupt_sequencer_if.slave  bus
);

  import cpu_pkg::*;

  localparam logic [2:0] LAST_CYCLE = 3'(SEQ_LEN - 1);

  // ---------------------------------------------------------------------------
  // Pin synchronisers
  // ---------------------------------------------------------------------------
  logic nmi_s;
  logic irq_s;

  pin_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.nmi_n),
    .sync_o  (nmi_s)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.irq_n),
    .sync_o  (irq_s)
  );

  // Only the I flag matters here; the other status bits pass by untouched.
  logic unused_psr_bits;
  assign unused_psr_bits = ^{bus.psr_in[7:3], bus.psr_in[1:0]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  seq_state_t state_q,       state_d;
  int_kind_t  kind_q,        kind_d;
  logic [2:0] cycle_q,       cycle_d;
  logic       brk_q,         brk_d;         // sequence was started by BRK
  logic       nmi_prev_q,    nmi_prev_d;
  logic       nmi_pending_q, nmi_pending_d;

  logic irq_req;
  logic nmi_edge;
  logic nmi_clear;
  logic in_seq;

  assign in_seq   = (state_q == ST_SEQ);
  assign irq_req  = ~irq_s & ~bus.psr_in[2];
  assign nmi_edge = nmi_prev_q & ~nmi_s;

  // The NMI request is consumed as the NMI sequence leaves cycle 5.
  assign nmi_clear = in_seq && (kind_q == NMI) && (cycle_q == 3'd5) && bus.rdy;

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    cycle_d    = cycle_q;
    brk_d      = brk_q;
    nmi_prev_d = nmi_s;

    // A new edge wins over a simultaneous clear.
    nmi_pending_d = nmi_edge | (nmi_pending_q & ~nmi_clear);

    case (state_q)
      ST_IDLE: begin
        if (bus.instr_boundary && bus.rdy) begin
          if (nmi_pending_q) begin
            state_d = ST_SEQ;
            kind_d  = NMI;
            cycle_d = 3'd0;
            brk_d   = 1'b0;
          end else if (irq_req) begin
            state_d = ST_SEQ;
            kind_d  = IRQ;
            cycle_d = 3'd0;
            brk_d   = 1'b0;
          end else if (bus.brk_decoded) begin
            state_d = ST_SEQ;
            kind_d  = BRK;
            cycle_d = 3'd0;
            brk_d   = 1'b1;
          end
        end
      end

      ST_SEQ: begin
        // Late NMI hijacks an IRQ/BRK sequence before its vector fetch; the
        // pushes already done are shared, only the vector changes.
        if ((kind_q == IRQ || kind_q == BRK) && nmi_pending_q && (cycle_q <= 3'd4)) begin
          kind_d = NMI;
        end
        if (bus.rdy) begin
          if (cycle_q == LAST_CYCLE) begin
            state_d = ST_IDLE;
            cycle_d = 3'd0;
          end else begin
            cycle_d = cycle_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cycle_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SEQ;
      kind_q        <= RESET;
      cycle_q       <= 3'd0;
      brk_q         <= 1'b0;
      nmi_prev_q    <= 1'b1;
      nmi_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      kind_q        <= kind_d;
      cycle_q       <= cycle_d;
      brk_q         <= brk_d;
      nmi_prev_q    <= nmi_prev_d;
      nmi_pending_q <= nmi_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  logic vec_cycle;
  assign vec_cycle = in_seq && (cycle_q == 3'd5 || cycle_q == 3'd6);

  assign bus.busy       = in_seq;
  assign bus.seq_cycle  = cycle_q;
  assign bus.int_kind   = kind_q;

  // RESET performs dummy reads instead of pushes.
  assign bus.stack_wr   = in_seq && (kind_q != RESET) &&
                          (cycle_q >= 3'd2) && (cycle_q <= 3'd4);

  assign bus.vector_addr = vec_cycle ?
                           (vector_base(kind_q) | {15'd0, cycle_q == 3'd6}) :
                           16'h0000;

  // Uses the kind the sequence started with, so a hijacked BRK still pushes B.
  assign bus.break_set  = in_seq && brk_q && (cycle_q == 3'd4);
  assign bus.manual_I   = in_seq && (cycle_q == 3'd5);
  assign bus.manual_set = bus.manual_I;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a transaction-level reference model of the sequencer.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  localparam int SYNC   = 2;
  localparam int SEQLEN = 7;
  localparam int K_BRK  = 0;
  localparam int K_IRQ  = 1;
  localparam int K_NMI  = 2;
  localparam int K_RST  = 3;

  logic clk;
  logic rst;

  interrupt_sequencer_if bus_if();

  interrupt_sequencer #(.SEQ_LEN(SEQLEN), .SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Reference model: pin history queues stand in for the synchronisers;
  // the sequence is tracked as "active / kind / step".
  bit m_nmi_hist[$];   // oldest first: [prev, synced, ..., newest]
  bit m_irq_hist[$];   // oldest first: [synced, ..., newest]
  bit m_pending;
  bit m_active;
  bit m_brk;
  int m_kind;
  int m_step;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_vector();
    logic [15:0] base;
    if (!m_active || m_step < 5) return 16'h0000;
    case (m_kind)
      K_NMI:   base = 16'hFFFA;
      K_RST:   base = 16'hFFFC;
      default: base = 16'hFFFE;
    endcase
    return base + ((m_step == 6) ? 16'd1 : 16'd0);
  endfunction

  // Apply the rules of one clock edge to the model, using the inputs the DUT
  // saw at that edge.
  task automatic model_edge();
    bit edge_seen;
    bit irq_req;
    bit clear;
    if (rst) begin
      m_nmi_hist = {};
      m_irq_hist = {};
      repeat (SYNC + 1) m_nmi_hist.push_back(1'b1);
      repeat (SYNC)     m_irq_hist.push_back(1'b1);
      m_pending = 1'b0;
      m_active  = 1'b1;
      m_kind    = K_RST;
      m_step    = 0;
      m_brk     = 1'b0;
    end else begin
      edge_seen = m_nmi_hist[0] && !m_nmi_hist[1];
      irq_req   = !m_irq_hist[0] && !bus_if.psr_in[2];
      clear     = m_active && m_kind == K_NMI && m_step == 5 && bus_if.rdy;
      if (m_active) begin
        if ((m_kind == K_IRQ || m_kind == K_BRK) && m_pending && m_step <= 4) m_kind = K_NMI;
        if (bus_if.rdy) begin
          if (m_step == SEQLEN - 1) begin
            m_active = 1'b0;
            m_step   = 0;
          end else begin
            m_step++;
          end
        end
      end else if (bus_if.instr_boundary && bus_if.rdy) begin
        if (m_pending || irq_req || bus_if.brk_decoded) begin
          m_active = 1'b1;
          m_step   = 0;
          m_kind   = m_pending ? K_NMI : (irq_req ? K_IRQ : K_BRK);
          m_brk    = (m_kind == K_BRK);
        end
      end
      if (edge_seen) m_pending = 1'b1;
      else if (clear) m_pending = 1'b0;
      m_nmi_hist.push_back(bus_if.nmi_n);
      void'(m_nmi_hist.pop_front());
      m_irq_hist.push_back(bus_if.irq_n);
      void'(m_irq_hist.pop_front());
    end
  endtask

  task automatic compare_all();
    check("busy",       16'(bus_if.busy),      16'(m_active));
    check("seq_cycle",  16'(bus_if.seq_cycle), 16'(m_step));
    if (m_active) check("int_kind", 16'(bus_if.int_kind), 16'(m_kind));
    check("stack_wr",   16'(bus_if.stack_wr),
          16'(m_active && m_kind != K_RST && m_step >= 2 && m_step <= 4));
    check("vector",     bus_if.vector_addr, model_vector());
    check("break_set",  16'(bus_if.break_set), 16'(m_active && m_brk && m_step == 4));
    check("manual_I",   16'(bus_if.manual_I),  16'(m_active && m_step == 5));
    check("manual_set", 16'(bus_if.manual_set), 16'(m_active && m_step == 5));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int nmi_seqs;
  bit prev_busy;

  initial begin
    n_vec = 0;
    n_err = 0;

    // ---- Reset and the RESET sequence ------------------------------------
    rst                   = 1'b1;
    bus_if.nmi_n          = 1'b1;
    bus_if.irq_n          = 1'b1;
    bus_if.psr_in         = 8'h24;
    bus_if.instr_boundary = 1'b0;
    bus_if.brk_decoded    = 1'b0;
    bus_if.rdy            = 1'b1;
    repeat (3) tick();
    check("rst_busy",  16'(bus_if.busy), 16'd1);
    check("rst_cycle", 16'(bus_if.seq_cycle), 16'd0);
    check("rst_kind",  16'(bus_if.int_kind), 16'd3);
    rst = 1'b0;
    repeat (5) tick();
    check("rst_vec_lo", bus_if.vector_addr, 16'hFFFC);
    tick();
    check("rst_vec_hi", bus_if.vector_addr, 16'hFFFD);
    tick();
    check("rst_done_busy", 16'(bus_if.busy), 16'd0);

    // ---- IRQ with I clear, then blocked with I set -----------------------
    bus_if.irq_n  = 1'b0;
    bus_if.psr_in = 8'h20;
    repeat (3) tick();
    bus_if.instr_boundary = 1'b1;
    tick();
    bus_if.instr_boundary = 1'b0;
    check("irq_kind", 16'(bus_if.int_kind), 16'd1);
    repeat (7) tick();
    bus_if.psr_in = 8'h24;
    repeat (2) tick();
    bus_if.instr_boundary = 1'b1;
    tick();
    bus_if.instr_boundary = 1'b0;
    check("irq_masked_busy", 16'(bus_if.busy), 16'd0);
    bus_if.irq_n  = 1'b1;
    bus_if.psr_in = 8'h20;
    repeat (3) tick();

    // ---- BRK -------------------------------------------------------------
    bus_if.brk_decoded    = 1'b1;
    bus_if.instr_boundary = 1'b1;
    tick();
    bus_if.brk_decoded    = 1'b0;
    bus_if.instr_boundary = 1'b0;
    check("brk_kind", 16'(bus_if.int_kind), 16'd0);
    repeat (4) tick();
    check("brk_break_set", 16'(bus_if.break_set), 16'd1);
    tick();
    check("brk_vec", bus_if.vector_addr, 16'hFFFE);
    repeat (3) tick();

    // ---- NMI hijacks an IRQ sequence -------------------------------------
    bus_if.irq_n = 1'b0;
    repeat (3) tick();
    bus_if.instr_boundary = 1'b1;
    tick();
    bus_if.instr_boundary = 1'b0;
    bus_if.irq_n          = 1'b1;
    tick();
    bus_if.nmi_n = 1'b0;          // falls during cycle 1
    repeat (4) tick();
    check("hijack_kind",   16'(bus_if.int_kind), 16'd2);
    check("hijack_vec",    bus_if.vector_addr, 16'hFFFA);
    check("hijack_no_brk", 16'(bus_if.stack_wr), 16'd0);
    repeat (2) tick();
    bus_if.instr_boundary = 1'b1;
    tick();
    bus_if.instr_boundary = 1'b0;
    check("hijack_no_second_nmi", 16'(bus_if.busy), 16'd0);
    bus_if.nmi_n = 1'b1;
    repeat (3) tick();

    // ---- NMI held low across two boundaries ------------------------------
    bus_if.nmi_n = 1'b0;
    nmi_seqs     = 0;
    prev_busy    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_if.instr_boundary = (i == 5 || i == 14);
      tick();
      if (bus_if.busy && !prev_busy && bus_if.int_kind == 2'd2) nmi_seqs++;
      prev_busy = bus_if.busy;
    end
    bus_if.instr_boundary = 1'b0;
    check("nmi_level_once", 16'(nmi_seqs), 16'd1);
    bus_if.nmi_n = 1'b1;
    repeat (3) tick();

    // ---- rdy stall in cycle 3 --------------------------------------------
    bus_if.brk_decoded    = 1'b1;
    bus_if.instr_boundary = 1'b1;
    tick();
    bus_if.brk_decoded    = 1'b0;
    bus_if.instr_boundary = 1'b0;
    repeat (3) tick();
    bus_if.rdy = 1'b0;
    repeat (4) begin
      tick();
      check("stall_cycle", 16'(bus_if.seq_cycle), 16'd3);
      check("stall_push",  16'(bus_if.stack_wr), 16'd1);
    end
    bus_if.rdy = 1'b1;
    repeat (3) tick();
    check("stall_last", 16'(bus_if.seq_cycle), 16'd6);
    tick();
    check("stall_done", 16'(bus_if.busy), 16'd0);

    // ---- Randomized traffic against the model ----------------------------
    for (int i = 0; i < 1500; i++) begin
      rst                   = ($urandom_range(0, 299) == 0);
      bus_if.rdy            = ($urandom_range(0, 4) != 0);
      bus_if.instr_boundary = ($urandom_range(0, 3) == 0);
      bus_if.brk_decoded    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 11) == 0) bus_if.nmi_n = ~bus_if.nmi_n;
      if ($urandom_range(0, 7) == 0)  bus_if.irq_n = ~bus_if.irq_n;
      if ($urandom_range(0, 9) == 0)  bus_if.psr_in = 8'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
